// File: rtl/line_wbuf_pkg.sv
// Shared constants and state encoding for the single-line write-back buffer.
package line_wbuf_pkg;
  localparam int LINE_OFFSET = 6;
  localparam int WB_BEAT_NUM = 4;
  localparam int WB_PTR_W    = 3;
  localparam int WB_IDX_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } wbuf_state_e;
endpackage

// File: rtl/line_wbuf_if.sv
// dcache / snoop / biu-stream signals of the write-back buffer; names are from the buffer's view.
interface line_wbuf_if
  import line_wbuf_pkg::*;
#(
  parameter int PADDR_SIZE = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  wb_req_i;
  logic [PADDR_SIZE-1:0] wb_addr_i;
  logic                  wb_wvalid_i;
  logic [DATA_WIDTH-1:0] wb_wdata_i;
  logic                  wb_ready_o;
  logic                  wb_done_o;
  logic                  wb_error_o;
  logic [PADDR_SIZE-1:0] snoop_addr_i;
  logic                  snoop_hit_o;
  logic                  grant_i;
  logic                  stream_writeline_req_o;
  logic [PADDR_SIZE-1:0] stream_addr_o;
  logic [DATA_WIDTH-1:0] stream_wdata_o;
  logic                  stream_wvalid_o;
  logic                  stream_wready_i;
  logic                  stream_write_done_i;
  logic                  stream_error_i;

  modport slave (
    input  wb_req_i, wb_addr_i, wb_wvalid_i, wb_wdata_i, snoop_addr_i, grant_i,
           stream_wready_i, stream_write_done_i, stream_error_i,
    output wb_ready_o, wb_done_o, wb_error_o, snoop_hit_o, stream_writeline_req_o,
           stream_addr_o, stream_wdata_o, stream_wvalid_o
  );

  modport master (
    output wb_req_i, wb_addr_i, wb_wvalid_i, wb_wdata_i, snoop_addr_i, grant_i,
           stream_wready_i, stream_write_done_i, stream_error_i,
    input  wb_ready_o, wb_done_o, wb_error_o, snoop_hit_o, stream_writeline_req_o,
           stream_addr_o, stream_wdata_o, stream_wvalid_o
  );
endinterface

// File: rtl/line_wbuf_mem.sv
// Line storage: one synchronous write port, one combinational read port, data not reset.
module line_wbuf_mem
  import line_wbuf_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  i_we,
  input  logic [WB_IDX_W-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [WB_IDX_W-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [WB_BEAT_NUM];

  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/line_wbuf.sv
// Single-entry dirty-line write-back buffer: takes one evicted line from the dcache and
// streams it to the biu once the port arbiter grants access.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | empty, wb_ready_o=1, waiting for a write-back request
//   ST_FILL  | collecting line beats from the dcache
//   ST_WAIT  | line complete, waiting for the port grant
//   ST_WRITE | stream write-line request active, beats popped by the biu
//   ST_RESP  | biu finished; report done/error for one cycle
module line_wbuf
  import line_wbuf_pkg::*;
#(
  parameter int PADDR_SIZE = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic       clk_i,
  input  logic       arst_i,
  line_wbuf_if.slave bus
);
  localparam logic [WB_PTR_W-1:0] PTR_LAST = WB_PTR_W'(WB_BEAT_NUM - 1);
  localparam logic [WB_PTR_W-1:0] PTR_END  = WB_PTR_W'(WB_BEAT_NUM);

  wbuf_state_e                      r_state;
  wbuf_state_e                      w_state_nxt;
  logic [PADDR_SIZE-LINE_OFFSET-1:0] r_line_addr;
  logic [WB_PTR_W-1:0]              r_wr_ptr;
  logic [WB_PTR_W-1:0]              r_rd_ptr;
  logic                             w_accept;
  logic                             w_fill_we;
  logic                             w_pop;
  logic                             w_rd_valid;
  logic                             w_ready;
  logic                             w_req;
  logic                             w_done;
  logic                             w_error;
  logic [DATA_WIDTH-1:0]            w_rdata;
  logic                             w_unused;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_rd_valid = (r_state == ST_WRITE) && (r_rd_ptr < PTR_END);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fill_we   = 1'b0;
    w_pop       = 1'b0;
    w_ready     = 1'b0;
    w_req       = 1'b0;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.wb_req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.wb_wvalid_i) begin
          w_fill_we = 1'b1;
          if (r_wr_ptr == PTR_LAST) w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.grant_i) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_req = 1'b1;
        w_pop = bus.stream_wready_i && w_rd_valid;
        if (bus.stream_write_done_i) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // request held here so the biu keeps driving its error flag
        w_req       = 1'b1;
        w_error     = bus.stream_error_i;
        w_done      = !bus.stream_error_i;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_line_addr <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (w_accept) begin
        r_line_addr <= bus.wb_addr_i[PADDR_SIZE-1:LINE_OFFSET];
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
      end
      if (w_fill_we) r_wr_ptr <= r_wr_ptr + WB_PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + WB_PTR_W'(1);
    end
  end

  line_wbuf_mem #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_i  (clk_i),
    .i_we   (w_fill_we),
    .i_waddr(r_wr_ptr[WB_IDX_W-1:0]),
    .i_wdata(bus.wb_wdata_i),
    .i_raddr(r_rd_ptr[WB_IDX_W-1:0]),
    .o_rdata(w_rdata)
  );

  assign bus.wb_ready_o             = w_ready;
  assign bus.wb_done_o              = w_done;
  assign bus.wb_error_o             = w_error;
  assign bus.stream_writeline_req_o = w_req;
  assign bus.stream_addr_o          = {r_line_addr, {LINE_OFFSET{1'b0}}};
  assign bus.stream_wdata_o         = w_rdata;
  assign bus.stream_wvalid_o        = w_rd_valid;
  assign bus.snoop_hit_o            = (r_state != ST_IDLE) &&
                                      (bus.snoop_addr_i[PADDR_SIZE-1:LINE_OFFSET] == r_line_addr);

  // byte-offset bits never matter: lines are always 64-byte aligned
  assign w_unused = ^{bus.wb_addr_i[LINE_OFFSET-1:0], bus.snoop_addr_i[LINE_OFFSET-1:0]};
endmodule

// File: tb/tb_line_wbuf.sv
// Bench for line_wbuf: a table of write-back transactions with a beat scoreboard,
// plus hand-written reset-abort and recovery sequences.
module tb_line_wbuf;
  import line_wbuf_pkg::*;

  localparam int PA = 32;
  localparam int DW = 128;

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;

  line_wbuf_if #(.PADDR_SIZE(PA), .DATA_WIDTH(DW)) bus ();

  line_wbuf #(.PADDR_SIZE(PA), .DATA_WIDTH(DW)) dut (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PA-1:0] addr;
    logic [PA-1:0] exp_addr;
    logic [PA-1:0] snoop;
    logic          exp_hit;
    int            fill_gap;
    int            grant_dly;
    int            pop_gap;
    int            biu_lat;
    logic          bus_err;
  } vec_t;

  vec_t          vecs[4];
  int            n_checks    = 0;
  int            n_errors    = 0;
  int            n_done      = 0;
  int            n_err_pulse = 0;
  int            exp_done    = 0;
  int            exp_err     = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard side: every beat the biu pops must match the next beat filled
  always @(negedge clk_i) begin
    #2;
    if (!arst_i && bus.stream_wvalid_o && bus.stream_wready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_underflow: got beat %0h, expected none", bus.stream_wdata_o);
      end else begin
        check("stream_wdata", bus.stream_wdata_o, exp_q.pop_front());
      end
    end
    if (bus.wb_done_o)  n_done++;
    if (bus.wb_error_o) n_err_pulse++;
  end

  task automatic clear_inputs();
    bus.wb_req_i            = 1'b0;
    bus.wb_addr_i           = '0;
    bus.wb_wvalid_i         = 1'b0;
    bus.wb_wdata_i          = '0;
    bus.snoop_addr_i        = '0;
    bus.grant_i             = 1'b0;
    bus.stream_wready_i     = 1'b0;
    bus.stream_write_done_i = 1'b0;
    bus.stream_error_i      = 1'b0;
  endtask

  // accept + fill; returns at the negedge where the block sits in WAIT
  task automatic accept_and_fill(input logic [PA-1:0] addr, input int gap);
    logic [DW-1:0] d;
    @(negedge clk_i);
    bus.wb_wvalid_i = 1'b1;
    bus.wb_wdata_i  = '1;
    #1 check("ready_idle", bus.wb_ready_o, 1'b1);
    @(negedge clk_i);
    bus.wb_req_i  = 1'b1;
    bus.wb_addr_i = addr;
    @(negedge clk_i);
    bus.wb_req_i    = 1'b0;
    bus.wb_addr_i   = '0;
    bus.wb_wvalid_i = 1'b0;
    #1 check("ready_fill", bus.wb_ready_o, 1'b0);
    for (int i = 0; i < WB_BEAT_NUM; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.wb_wvalid_i = 1'b0;
        @(negedge clk_i);
      end
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.wb_wvalid_i = 1'b1;
      bus.wb_wdata_i  = d;
      exp_q.push_back(d);
      @(negedge clk_i);
    end
    bus.wb_wvalid_i = 1'b0;
    bus.wb_wdata_i  = '0;
  endtask

  task automatic run_vec(input vec_t v);
    accept_and_fill(v.addr, v.fill_gap);
    bus.snoop_addr_i = v.snoop;
    #1;
    check("snoop_hit", bus.snoop_hit_o, v.exp_hit);
    check("req_before_grant", bus.stream_writeline_req_o, 1'b0);
    for (int g = 0; g < v.grant_dly; g++) begin
      @(negedge clk_i);
      #1 check("req_no_grant", bus.stream_writeline_req_o, 1'b0);
    end
    bus.grant_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("req_write", bus.stream_writeline_req_o, 1'b1);
    check("stream_addr", bus.stream_addr_o, v.exp_addr);
    check("wvalid_write", bus.stream_wvalid_o, 1'b1);
    bus.wb_req_i  = 1'b1;
    bus.wb_addr_i = 32'hDEAD_BEC0;
    for (int i = 0; i < WB_BEAT_NUM; i++) begin
      for (int g = 0; g < v.pop_gap; g++) begin
        bus.stream_wready_i = 1'b0;
        @(negedge clk_i);
      end
      bus.stream_wready_i = 1'b1;
      @(negedge clk_i);
    end
    #1;
    check("wvalid_drained", bus.stream_wvalid_o, 1'b0);
    check("addr_held", bus.stream_addr_o, v.exp_addr);
    @(negedge clk_i);
    bus.stream_wready_i = 1'b0;
    for (int g = 0; g < v.biu_lat; g++) @(negedge clk_i);
    bus.stream_write_done_i = 1'b1;
    @(negedge clk_i);
    bus.stream_write_done_i = 1'b0;
    bus.wb_req_i            = 1'b0;
    bus.stream_error_i      = v.bus_err;
    #1;
    check("done_pulse", bus.wb_done_o, !v.bus_err);
    check("error_pulse", bus.wb_error_o, v.bus_err);
    check("req_resp", bus.stream_writeline_req_o, 1'b1);
    @(negedge clk_i);
    bus.stream_error_i = 1'b0;
    bus.grant_i        = 1'b0;
    bus.snoop_addr_i   = v.exp_addr;
    #1;
    check("req_dropped", bus.stream_writeline_req_o, 1'b0);
    check("ready_back", bus.wb_ready_o, 1'b1);
    check("done_one_cycle", bus.wb_done_o, 1'b0);
    check("snoop_after_done", bus.snoop_hit_o, 1'b0);
    check("beats_consumed", exp_q.size(), 0);
    if (v.bus_err) exp_err++;
    else           exp_done++;
  endtask

  initial begin
    int pulses_before;
    vecs[0] = '{addr: 32'h8000_0040, exp_addr: 32'h8000_0040, snoop: 32'h8000_007C, exp_hit: 1'b1,
                fill_gap: 0, grant_dly: 0, pop_gap: 0, biu_lat: 0, bus_err: 1'b0};
    vecs[1] = '{addr: 32'h8000_0040, exp_addr: 32'h8000_0040, snoop: 32'h8000_0080, exp_hit: 1'b0,
                fill_gap: 2, grant_dly: 10, pop_gap: 1, biu_lat: 2, bus_err: 1'b0};
    vecs[2] = '{addr: 32'h1234_5678, exp_addr: 32'h1234_5640, snoop: 32'h1234_567F, exp_hit: 1'b1,
                fill_gap: 1, grant_dly: 3, pop_gap: 0, biu_lat: 1, bus_err: 1'b1};
    vecs[3] = '{addr: 32'hFFFF_FFC0, exp_addr: 32'hFFFF_FFC0, snoop: 32'h7FFF_FFC0, exp_hit: 1'b0,
                fill_gap: 0, grant_dly: 1, pop_gap: 2, biu_lat: 0, bus_err: 1'b0};

    clear_inputs();
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ready", bus.wb_ready_o, 1'b1);
    check("rst_req", bus.stream_writeline_req_o, 1'b0);
    check("rst_wvalid", bus.stream_wvalid_o, 1'b0);
    check("rst_done", bus.wb_done_o, 1'b0);
    check("rst_error", bus.wb_error_o, 1'b0);
    check("rst_snoop", bus.snoop_hit_o, 1'b0);
    @(negedge clk_i);
    arst_i = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // reset lands mid-WRITE after two beats have gone out
    pulses_before = n_done + n_err_pulse;
    accept_and_fill(32'h4000_0000, 0);
    bus.grant_i      = 1'b1;
    bus.snoop_addr_i = 32'h4000_0000;
    @(negedge clk_i);
    bus.stream_wready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    bus.stream_wready_i = 1'b0;
    #1 check("req_before_reset", bus.stream_writeline_req_o, 1'b1);
    #2 arst_i = 1'b1;
    #1;
    check("rst_async_req", bus.stream_writeline_req_o, 1'b0);
    check("rst_async_ready", bus.wb_ready_o, 1'b1);
    check("rst_async_wvalid", bus.stream_wvalid_o, 1'b0);
    check("rst_async_snoop", bus.snoop_hit_o, 1'b0);
    check("rst_left_beats", exp_q.size(), 2);
    clear_inputs();
    repeat (3) @(negedge clk_i);
    arst_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    check("rst_no_pulse", n_done + n_err_pulse, pulses_before);

    run_vec(vecs[0]);

    repeat (2) @(negedge clk_i);
    check("total_done", n_done, exp_done);
    check("total_error", n_err_pulse, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/line_wbuf.md
# line_wbuf

Single-entry dirty-line write-back buffer between the data cache and the bus interface unit's stream write port. It accepts one evicted cache line (BEAT_NUM × 128 bit) from the dcache and holds it. When the external port arbiter grants access, it issues a stream write-line request and supplies 128-bit beats on demand. It reports completion or bus error back to the cache, and flags address hits so a refill of the same line stalls until write-back ends.

## Interface
- PADDR_SIZE, 32, physical address width
- DATA_WIDTH, 128, beat width (fixed)
- BEAT_NUM, 4, beats per line (fixed); line = 64 bytes, LINE_OFFSET = 6
- clk_i  in  1  single clock
- arst_i  in  1  reset, asynchronous, active-high
- wb_req_i  in  1  dcache requests write-back; accepted when wb_ready_o=1
- wb_addr_i  in  PADDR_SIZE  line address, sampled on accept; low LINE_OFFSET bits forced to 0
- wb_wvalid_i  in  1  line beat valid (FILL state only)
- wb_wdata_i  in  DATA_WIDTH  line beat, beat 0 first
- wb_ready_o  out  1  buffer empty, can accept
- wb_done_o  out  1  one-cycle pulse, line written successfully
- wb_error_o  out  1  one-cycle pulse, bus error on write-back
- snoop_addr_i  in  PADDR_SIZE  address of pending cache refill
- snoop_hit_o  out  1  snoop line equals buffered line (combinational)
- grant_i  in  1  port arbiter grant; no other biu requester is active while high
- stream_writeline_req_o  out  1  to biu, held until transaction ends
- stream_addr_o  out  PADDR_SIZE  buffered line address
- stream_wdata_o  out  DATA_WIDTH  mem[rd_ptr], combinational from the read pointer
- stream_wvalid_o  out  1  rd_ptr < BEAT_NUM while in WRITE
- stream_wready_i  in  1  biu pops current beat
- stream_write_done_i  in  1  biu saw B response
- stream_error_i  in  1  biu error indication, valid the cycle after done

## Operation
- States: IDLE, FILL, WAIT, WRITE, RESP.
- IDLE: wb_ready_o=1. On wb_req_i, latch address, wr_ptr=0, rd_ptr=0, and go to FILL. A wb_wvalid_i in the accept cycle is ignored.
- FILL: each wb_wvalid_i writes mem[wr_ptr] and increments wr_ptr. Gaps are allowed. The beat with wr_ptr=BEAT_NUM-1 moves the block to WAIT.
- WAIT: go to WRITE when grant_i=1.
- WRITE: stream_writeline_req_o=1. Each stream_wready_i increments rd_ptr; pulses beyond BEAT_NUM are ignored and rd_ptr saturates. stream_write_done_i moves the block to RESP.
- RESP: stream_writeline_req_o stays 1 so the biu error signal stays ungated. If stream_error_i=1, pulse wb_error_o; otherwise pulse wb_done_o. Go to IDLE. The line is dropped either way; the cache owns the retry policy.
- snoop_hit_o = (state≠IDLE) & (snoop_addr_i[PADDR_SIZE-1:6] == line_addr[PADDR_SIZE-1:6]).
- wb_req_i outside IDLE and wb_wvalid_i outside FILL are ignored.
- stream_wready_i and stream_write_done_i outside WRITE are ignored.

## Timing
- Reset values: state=IDLE, wb_ready_o=1, stream_writeline_req_o=0, stream_wvalid_o=0, wb_done_o=0, wb_error_o=0, pointers=0.
- An asserted reset mid-transfer aborts immediately; no done or error pulse is produced.
- Accept at cycle T puts the block in FILL at T+1. The first beat is taken at T+1 at the earliest.
- Last beat at cycle N puts the block in WAIT at N+1. With grant at N+1, WRITE and the request start at N+2.
- The request drops in the cycle after RESP. Done/error pulses come 1 cycle after stream_write_done_i.
- Minimum write-back occupancy, accept to ready: 1 + BEAT_NUM + 1 + biu latency + 2 cycles.
- The pointers are 3 bits wide so they can reach BEAT_NUM. The memory index uses the low 2 bits.

## Structure
- The shared package holds:
  - the line_wbuf state enum (3 bits);
  - LINE_OFFSET = 6;
  - WB_BEAT_NUM = 4.
- Sub-module line_wbuf_mem: 4×128 register file with one synchronous write port and one combinational read port. No reset on the data.
- The FSM, pointers, address latch and snoop compare live in the top level.

## Test plan
- Basic write-back: accept addr 0x8000_0040, 4 beats A0..A3, grant immediately, biu pops beats and returns OKAY → stream_addr_o=0x8000_0040; stream_wdata_o sequence A0..A3; wb_done_o pulses once; wb_ready_o returns to 1.
- Gapped fill and late grant: beats with 2-cycle gaps, grant held low 10 cycles → stream_writeline_req_o stays 0 until grant; data order is preserved.
- Bus error: biu asserts done, then stream_error_i=1 in the following cycle → wb_error_o pulses exactly once; wb_done_o stays 0; state is IDLE.
- Snoop: line buffered at 0x8000_0040, snoop 0x8000_007C → hit=1; snoop 0x8000_0080 → hit=0; after wb_done_o, snoop 0x8000_0040 → hit=0.
- Illegal inputs: wb_req_i during WRITE, wb_wvalid_i in IDLE, a 5th stream_wready_i → all ignored; buffered data and address are unchanged.
- Reset during WRITE after 2 pops → request drops asynchronously; wb_ready_o=1; no pulses.
